// File: rtl/sum_bcd_display_pkg.sv
// Shared definitions for the sum_bcd_display block.
// - FSM state encoding (IDLE / SHIFT / DONE)
// - Active-low seven-segment codes, bit0=a .. bit6=g
// - Width constants and the double-dabble nibble adjust helper
package sum_bcd_display_pkg;

  localparam int VALUE_W    = 10;
  localparam int NUM_DIGITS = 4;
  localparam int BCD_W      = 4 * NUM_DIGITS;
  localparam int SHIFT_W    = BCD_W + VALUE_W;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Double-dabble correction: every BCD nibble >= 5 gets +3 so that the
  // following left shift carries correctly into the next decimal digit.
  function automatic logic [BCD_W-1:0] bcd_add3(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] res;
    res = bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) begin
        res[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/sum_bcd_display_seg7_digit.sv
// One decimal digit to active-low seven-segment decoder (purely combinational).
// Ports:
//   i_bcd   [3:0]  BCD digit; codes 10..15 decode as blank
//   i_blank        force the digit dark
//   o_seg   [6:0]  active-low segments, bit0=a .. bit6=g
module seg7_digit
  import sum_bcd_display_pkg::*;
(
  input  logic [3:0] i_bcd,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    if (!i_blank) begin
      case (i_bcd)
        4'd0:    o_seg = SEG_0;
        4'd1:    o_seg = SEG_1;
        4'd2:    o_seg = SEG_2;
        4'd3:    o_seg = SEG_3;
        4'd4:    o_seg = SEG_4;
        4'd5:    o_seg = SEG_5;
        4'd6:    o_seg = SEG_6;
        4'd7:    o_seg = SEG_7;
        4'd8:    o_seg = SEG_8;
        4'd9:    o_seg = SEG_9;
        default: o_seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/sum_bcd_display.sv
// Decimal display stage for the accumulator Sum.
// A sequential shift-add-3 converter (one bit per clock) turns the 10-bit
// binary Value into four BCD digits whenever Value differs from the last
// converted value. Digit registers update only when a conversion completes,
// so HEX outputs never show partial results.
// Ports:
//   CLOCK_50          system clock, rising edge
//   Reset             synchronous, active-high
//   Value   [9:0]     binary value to display (0..1023)
//   HEX0..HEX3 [6:0]  ones..thousands digits, active-low segments
//   Busy              conversion in progress (SHIFT or DONE)
//   Done              one-cycle pulse when new digits first appear
//   o_dbg_state [1:0] current FSM state (state_t encoding), for observation
module sum_bcd_display
  import sum_bcd_display_pkg::*;
#(
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic         CLOCK_50,
  input  logic         Reset,
  input  logic [9:0]   Value,
  output logic [6:0]   HEX0,
  output logic [6:0]   HEX1,
  output logic [6:0]   HEX2,
  output logic [6:0]   HEX3,
  output logic         Busy,
  output logic         Done,
  output logic [1:0]   o_dbg_state
);

  state_t               r_state;
  state_t               w_next_state;
  logic [SHIFT_W-1:0]   r_shift;      // {BCD[15:0], bin[9:0]}
  logic [CNT_W-1:0]     r_bit_cnt;
  logic [VALUE_W-1:0]   r_captured;
  logic [VALUE_W-1:0]   r_last;
  logic [BCD_W-1:0]     r_digits;     // {d3, d2, d1, d0}
  logic                 r_done;

  logic                 w_changed;
  logic [SHIFT_W-1:0]   w_shift_adj;
  logic [NUM_DIGITS-1:0] w_blank;
  logic [6:0]           w_seg [NUM_DIGITS];

  assign w_changed   = (Value != r_last);
  assign w_shift_adj = {bcd_add3(r_shift[SHIFT_W-1:VALUE_W]), r_shift[VALUE_W-1:0]};

  // State register
  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (w_changed) w_next_state = ST_SHIFT;
      ST_SHIFT: if (r_bit_cnt == CNT_W'(1)) w_next_state = ST_DONE;
      ST_DONE:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    Busy        = (r_state == ST_SHIFT) || (r_state == ST_DONE);
    Done        = r_done;
    o_dbg_state = r_state;
  end

  // Datapath: shift register, bit counter, captured/last values, digits.
  // Done is a registered pulse: set while leaving DONE, cleared otherwise.
  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_captured <= '0;
      r_last     <= '0;
      r_digits   <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_changed) begin
            r_shift    <= {{BCD_W{1'b0}}, Value};
            r_captured <= Value;
            r_bit_cnt  <= CNT_W'(VALUE_W);
          end
        end
        ST_SHIFT: begin
          r_shift   <= {w_shift_adj[SHIFT_W-2:0], 1'b0};
          r_bit_cnt <= r_bit_cnt - CNT_W'(1);
        end
        ST_DONE: begin
          r_digits <= r_shift[SHIFT_W-1:VALUE_W];
          r_last   <= r_captured;
          r_done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Leading-zero blanking from the digit registers; ones digit always shown.
  always_comb begin
    w_blank    = '0;
    w_blank[3] = BLANK_LEADING && (r_digits[15:12] == 4'd0);
    w_blank[2] = w_blank[3] && (r_digits[11:8] == 4'd0);
    w_blank[1] = w_blank[2] && (r_digits[7:4] == 4'd0);
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    seg7_digit u_seg (
      .i_bcd   (r_digits[g*4 +: 4]),
      .i_blank (w_blank[g]),
      .o_seg   (w_seg[g])
    );
  end

  assign HEX0 = w_seg[0];
  assign HEX1 = w_seg[1];
  assign HEX2 = w_seg[2];
  assign HEX3 = w_seg[3];

endmodule

// File: tb/tb_sum_bcd_display.sv
// Bench for sum_bcd_display: two instances (leading blanking on / off) share
// the same stimulus. A reference model captures values at the abstract level
// (idle + changed -> capture, result appears 11 busy cycles later) and pushes
// each captured value into exp_q; the monitor pops on every DUT Done and
// checks the decimal rendering, plus Busy/Done/HEX every cycle.
module tb_sum_bcd_display;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] val;

  logic [6:0] hb0, hb1, hb2, hb3, hn0, hn1, hn2, hn3;
  logic       busy_b, done_b, busy_n, done_n;
  logic [1:0] st_b, st_n;

  int checks = 0;
  int errors = 0;

  logic [9:0] exp_q[$];

  // Reference model state
  int         m_cnt  = 0;     // busy cycles remaining
  logic [9:0] m_last = '0;
  logic [9:0] m_cap  = '0;
  bit         m_done = 1'b0;
  int         m_rst_cnt = 0;
  // Monitor state
  int         mon_rst_seen = 0;
  logic [9:0] mon_val = '0;

  always #10 clk = ~clk;

  sum_bcd_display #(.BLANK_LEADING(1'b1)) dut_b (
    .CLOCK_50(clk), .Reset(rst), .Value(val),
    .HEX0(hb0), .HEX1(hb1), .HEX2(hb2), .HEX3(hb3),
    .Busy(busy_b), .Done(done_b), .o_dbg_state(st_b)
  );

  sum_bcd_display #(.BLANK_LEADING(1'b0)) dut_n (
    .CLOCK_50(clk), .Reset(rst), .Value(val),
    .HEX0(hn0), .HEX1(hn1), .HEX2(hn2), .HEX3(hn3),
    .Busy(busy_n), .Done(done_n), .o_dbg_state(st_n)
  );

  task automatic chk(input string name, input logic [27:0] act, input logic [27:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    logic [6:0] tbl [10];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    return tbl[d];
  endfunction

  // {HEX3, HEX2, HEX1, HEX0} for a decimal value
  function automatic logic [27:0] exp_hex(input int v, input bit blank_lead);
    logic [27:0] r;
    int pw;
    pw = 1;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      if (blank_lead && i > 0 && v < pw) r[i*7 +: 7] = 7'h7F;
      else r[i*7 +: 7] = seg_of((v / pw) % 10);
      pw = pw * 10;
    end
    return r;
  endfunction

  // Reference model
  always @(posedge clk) begin
    m_done = 1'b0;
    if (rst) begin
      m_cnt  = 0;
      m_last = '0;
      exp_q.delete();
      m_rst_cnt++;
    end else if (m_cnt == 0) begin
      if (val != m_last) begin
        m_cap = val;
        m_cnt = 11;
        exp_q.push_back(val);
      end
    end else begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_last = m_cap;
        m_done = 1'b1;
      end
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (mon_rst_seen != m_rst_cnt) begin
      mon_rst_seen = m_rst_cnt;
      mon_val = '0;
    end
    chk("busy_b", 28'(busy_b), 28'(m_cnt != 0));
    chk("busy_n", 28'(busy_n), 28'(m_cnt != 0));
    chk("done_b", 28'(done_b), 28'(m_done));
    chk("done_n", 28'(done_n), 28'(m_done));
    if (done_b) begin
      if (exp_q.size() == 0) begin
        chk("done_with_empty_queue", 28'(1), 28'(0));
      end else begin
        mon_val = exp_q.pop_front();
      end
    end
    chk("hex_blank",   {hb3, hb2, hb1, hb0}, exp_hex(int'(mon_val), 1'b1));
    chk("hex_noblank", {hn3, hn2, hn1, hn0}, exp_hex(int'(mon_val), 1'b0));
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_busy(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (busy_b) seen = 1'b1;
    end
    if (!seen) chk("busy_timeout", 28'(0), 28'(1));
  endtask

  initial begin
    int sel;
    logic [9:0] edge_vals [8];
    edge_vals = '{10'd0, 10'd9, 10'd10, 10'd99, 10'd999, 10'd1000, 10'd1023, 10'd101};

    rst = 1'b1;
    val = '0;
    tick(3);
    rst = 1'b0;
    tick(50);

    // Directed values
    val = 10'd961;  tick(20);
    val = 10'd1023; tick(20);
    val = 10'd100;  tick(20);

    // Change while busy: captured value shown first, then re-trigger
    val = 10'd5;
    wait_busy(5);
    tick(3);
    val = 10'd7;
    tick(40);

    // Reset during the 6th SHIFT cycle
    val = 10'd961;
    wait_busy(5);
    tick(5);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(30);

    // Return to last value while busy
    val = 10'd42;
    wait_busy(5);
    tick(2);
    val = 10'd961;
    tick(40);

    // Randomised values, boundaries mixed in
    for (int n = 0; n < 60; n++) begin
      sel = int'($urandom_range(0, 3));
      if (sel == 0) val = edge_vals[$urandom_range(0, 7)];
      else val = 10'($urandom_range(0, 1023));
      tick(int'($urandom_range(1, 20)));
    end
    tick(40);

    chk("queue_drained", 28'(exp_q.size()), 28'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
